// File: rtl/irq_gateway.sv
`default_nettype none
// ============================================================================
// Module   : irq_gateway
// Brief    : External interrupt gateway with fixed-priority claim/complete.
// Revision : 1.0
// ============================================================================
module irq_gateway #(
  parameter int NSRC = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_src,
  input  logic [31:0]     bus_addr,
  input  logic            bus_wr,
  input  logic            bus_rd,
  input  logic [31:0]     bus_wdata,
  output logic [31:0]     bus_rdata,
  output logic            irq_out
);

  localparam logic [7:0] c_addr_pending = 8'h00;
  localparam logic [7:0] c_addr_enable  = 8'h04;
  localparam logic [7:0] c_addr_edge    = 8'h08;
  localparam logic [7:0] c_addr_claim   = 8'h0C;

  localparam logic [1:0] c_st_idle    = 2'd0;
  localparam logic [1:0] c_st_assert  = 2'd1;
  localparam logic [1:0] c_st_service = 2'd2;

  logic [NSRC-1:0] sync1_q, sync2_q, prev_q;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] enable_q, edge_sel_q;
  logic [1:0]      state_q, state_d;
  logic [4:0]      claimed_id_q, claimed_id_d;

  logic [7:0]      w_addr;
  logic [NSRC-1:0] w_rise, w_active;
  logic [4:0]      w_cand_id;
  logic            w_sel_claim, w_claim, w_complete;
  logic            w_unused_bits;

  assign w_addr        = bus_addr[7:0];
  assign w_unused_bits = ^{bus_addr[31:8], bus_wdata};
  assign w_rise        = sync2_q & ~prev_q;
  assign w_active      = pending_q & enable_q;
  assign w_sel_claim   = (w_addr == c_addr_claim);

  // A read that collides with a write at CLAIM never claims.
  assign w_claim    = bus_rd && !bus_wr && w_sel_claim && !reset &&
                      (state_q == c_st_assert) && (w_cand_id != 5'd0);
  assign w_complete = bus_wr && w_sel_claim && !reset &&
                      (state_q == c_st_service) && (bus_wdata[4:0] == claimed_id_q);

  always_comb begin
    w_cand_id = 5'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_active[i]) w_cand_id = 5'(i + 1);
    end
  end

  always_comb begin
    claimed_id_d = claimed_id_q;
    if (w_claim)         claimed_id_d = w_cand_id;
    else if (w_complete) claimed_id_d = 5'd0;
  end

  // Level pending looks at the next claimed id so the claim edge clears it
  // and the complete edge re-arms it without a dead cycle.
  generate
    for (genvar i = 0; i < NSRC; i++) begin : g_src
      localparam logic [4:0] c_id = 5'(i + 1);
      assign pending_d[i] = edge_sel_q[i]
          ? (w_rise[i] | (pending_q[i] & ~(w_claim && (w_cand_id == c_id))))
          : (sync2_q[i] & (claimed_id_d != c_id));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) state_q <= c_st_idle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle:    if (w_cand_id != 5'd0) state_d = c_st_assert;
      c_st_assert: begin
        if (w_claim)                 state_d = c_st_service;
        else if (w_cand_id == 5'd0)  state_d = c_st_idle;
      end
      c_st_service: if (w_complete)  state_d = c_st_idle;
      default:                       state_d = c_st_idle;
    endcase
  end

  always_comb begin
    irq_out = (state_q == c_st_assert);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      prev_q       <= '0;
      pending_q    <= '0;
      enable_q     <= '0;
      edge_sel_q   <= '0;
      claimed_id_q <= 5'd0;
    end else begin
      sync1_q      <= irq_src;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      pending_q    <= pending_d;
      claimed_id_q <= claimed_id_d;
      if (bus_wr && (w_addr == c_addr_enable)) enable_q   <= bus_wdata[NSRC-1:0];
      if (bus_wr && (w_addr == c_addr_edge))   edge_sel_q <= bus_wdata[NSRC-1:0];
    end
  end

  always_comb begin
    bus_rdata = 32'd0;
    if (bus_rd && !reset) begin
      case (w_addr)
        c_addr_pending: bus_rdata = 32'(pending_q);
        c_addr_enable:  bus_rdata = 32'(enable_q);
        c_addr_edge:    bus_rdata = 32'(edge_sel_q);
        c_addr_claim:   if (w_claim) bus_rdata = 32'(w_cand_id);
        default:        bus_rdata = 32'd0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_irq_gateway.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_gateway
// Brief    : Directed self-checking bench for irq_gateway.
// Revision : 1.0
// ============================================================================
module tb_irq_gateway;

  logic        clk;
  logic        reset;
  logic [7:0]  irq_src;
  logic [31:0] bus_addr;
  logic        bus_wr;
  logic        bus_rd;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        irq_out;

  int checks = 0;
  int errors = 0;

  irq_gateway #(.NSRC(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .irq_src   (irq_src),
    .bus_addr  (bus_addr),
    .bus_wr    (bus_wr),
    .bus_rd    (bus_rd),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .irq_out   (irq_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, required finish");
    $fatal(1);
  end

  // Bus helpers are entered on a negedge and return on the following negedge.
  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    bus_addr  = {24'h0, a};
    bus_wdata = d;
    bus_wr    = 1'b1;
    @(negedge clk);
    bus_wr    = 1'b0;
    bus_addr  = 32'h0;
    bus_wdata = 32'h0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    bus_addr = {24'h0, a};
    bus_rd   = 1'b1;
    #1 d = bus_rdata;
    @(negedge clk);
    bus_rd   = 1'b0;
    bus_addr = 32'h0;
  endtask

  task automatic wait_irq(input string name, input int max_cycles);
    int n = 0;
    while (irq_out !== 1'b1 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (irq_out !== 1'b1) begin
      errors++;
      $display("FAIL %s: irq_out=%b after %0d cycles, required 1", name, irq_out, n);
    end
  endtask

  task automatic pulse_src0();
    irq_src[0] = 1'b1;
    repeat (3) @(negedge clk);
    irq_src[0] = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (irq_out !== 1'b0) begin
      errors++; $display("FAIL reset_irq: irq_out=%b required 0", irq_out);
    end
    bus_write(8'h04, 32'hFF);
    reset = 1'b0;
    @(negedge clk);
    bus_read(8'h04, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL reset_write_ignored: ENABLE=%h required 0", d);
    end
    bus_read(8'h08, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL reset_edge_sel: EDGE_SEL=%h required 0", d);
    end
    bus_read(8'h00, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL reset_pending: PENDING=%h required 0", d);
    end
  endtask

  task automatic test_edge();
    logic [31:0] d;
    bus_write(8'h04, 32'h1);
    bus_write(8'h08, 32'h1);
    irq_src[0] = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (irq_out !== 1'b0) begin
      errors++; $display("FAIL edge_latency_early: irq_out=%b required 0 after 3 edges", irq_out);
    end
    irq_src[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (irq_out !== 1'b1) begin
      errors++; $display("FAIL edge_latency: irq_out=%b required 1 after 4 edges", irq_out);
    end
    bus_read(8'h0C, d);
    checks++;
    if (d !== 32'd1) begin
      errors++; $display("FAIL edge_claim: CLAIM=%0d required 1", d);
    end
    checks++;
    if (irq_out !== 1'b0) begin
      errors++; $display("FAIL edge_irq_after_claim: irq_out=%b required 0", irq_out);
    end
    bus_read(8'h00, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL edge_pending_cleared: PENDING=%h required 0", d);
    end
    bus_write(8'h0C, 32'd1);
    repeat (3) @(negedge clk);
    checks++;
    if (irq_out !== 1'b0) begin
      errors++; $display("FAIL edge_after_complete: irq_out=%b required 0", irq_out);
    end
  endtask

  task automatic test_priority();
    logic [31:0] d;
    bus_write(8'h08, 32'h0);
    bus_write(8'h04, 32'hFF);
    irq_src = 8'h24;
    wait_irq("prio_assert", 8);
    bus_read(8'h0C, d);
    checks++;
    if (d !== 32'd3) begin
      errors++; $display("FAIL prio_claim1: CLAIM=%0d required 3", d);
    end
    bus_write(8'h0C, 32'd3);
    checks++;
    if (irq_out !== 1'b0) begin
      errors++; $display("FAIL prio_idle_gap: irq_out=%b required 0", irq_out);
    end
    @(negedge clk);
    checks++;
    if (irq_out !== 1'b1) begin
      errors++; $display("FAIL prio_reassert: irq_out=%b required 1", irq_out);
    end
    bus_read(8'h0C, d);
    checks++;
    if (d !== 32'd3) begin
      errors++; $display("FAIL prio_claim2: CLAIM=%0d required 3", d);
    end
    irq_src = 8'h20;
    repeat (4) @(negedge clk);
    bus_write(8'h0C, 32'd3);
    @(negedge clk);
    checks++;
    if (irq_out !== 1'b1) begin
      errors++; $display("FAIL prio_reassert6: irq_out=%b required 1", irq_out);
    end
    bus_read(8'h0C, d);
    checks++;
    if (d !== 32'd6) begin
      errors++; $display("FAIL prio_claim6: CLAIM=%0d required 6", d);
    end
    irq_src = 8'h00;
    repeat (4) @(negedge clk);
    bus_write(8'h0C, 32'd6);
    repeat (2) @(negedge clk);
    checks++;
    if (irq_out !== 1'b0) begin
      errors++; $display("FAIL prio_quiet: irq_out=%b required 0", irq_out);
    end
  endtask

  task automatic test_bad_complete();
    logic [31:0] d;
    irq_src = 8'h04;
    wait_irq("bad_assert", 8);
    bus_read(8'h0C, d);
    checks++;
    if (d !== 32'd3) begin
      errors++; $display("FAIL bad_claim: CLAIM=%0d required 3", d);
    end
    bus_write(8'h0C, 32'd4);
    repeat (3) @(negedge clk);
    checks++;
    if (irq_out !== 1'b0) begin
      errors++; $display("FAIL bad_complete_ignored: irq_out=%b required 0", irq_out);
    end
    bus_read(8'h0C, d);
    checks++;
    if (d !== 32'd0) begin
      errors++; $display("FAIL service_claim_zero: CLAIM=%0d required 0", d);
    end
    bus_write(8'h0C, 32'd3);
    @(negedge clk);
    checks++;
    if (irq_out !== 1'b1) begin
      errors++; $display("FAIL good_complete: irq_out=%b required 1", irq_out);
    end
    bus_read(8'h0C, d);
    irq_src = 8'h00;
    repeat (4) @(negedge clk);
    bus_write(8'h0C, 32'd3);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    bus_write(8'h04, 32'h1);
    bus_write(8'h08, 32'h1);
    pulse_src0();
    wait_irq("b2b_assert", 4);
    bus_read(8'h0C, d);
    checks++;
    if (d !== 32'd1) begin
      errors++; $display("FAIL b2b_claim: CLAIM=%0d required 1", d);
    end
    pulse_src0();
    repeat (2) @(negedge clk);
    bus_read(8'h00, d);
    checks++;
    if (d !== 32'h1) begin
      errors++; $display("FAIL b2b_pending: PENDING=%h required 1", d);
    end
    checks++;
    if (irq_out !== 1'b0) begin
      errors++; $display("FAIL b2b_in_service: irq_out=%b required 0", irq_out);
    end
    bus_write(8'h0C, 32'd1);
    @(negedge clk);
    checks++;
    if (irq_out !== 1'b1) begin
      errors++; $display("FAIL b2b_reassert: irq_out=%b required 1", irq_out);
    end
    // Read and write together at CLAIM while asserting: no claim happens.
    bus_addr = 32'h0C; bus_wdata = 32'd1; bus_rd = 1'b1; bus_wr = 1'b1;
    #1;
    checks++;
    if (bus_rdata !== 32'd0) begin
      errors++; $display("FAIL rdwr_assert_rdata: rdata=%0d required 0", bus_rdata);
    end
    @(negedge clk);
    bus_rd = 1'b0; bus_wr = 1'b0; bus_addr = 32'h0; bus_wdata = 32'h0;
    checks++;
    if (irq_out !== 1'b1) begin
      errors++; $display("FAIL rdwr_no_claim: irq_out=%b required 1", irq_out);
    end
    bus_read(8'h0C, d);
    checks++;
    if (d !== 32'd1) begin
      errors++; $display("FAIL b2b_claim2: CLAIM=%0d required 1", d);
    end
    // Read and write together while in service: the complete is taken.
    bus_addr = 32'h0C; bus_wdata = 32'd1; bus_rd = 1'b1; bus_wr = 1'b1;
    #1;
    checks++;
    if (bus_rdata !== 32'd0) begin
      errors++; $display("FAIL rdwr_service_rdata: rdata=%0d required 0", bus_rdata);
    end
    @(negedge clk);
    bus_rd = 1'b0; bus_wr = 1'b0; bus_addr = 32'h0; bus_wdata = 32'h0;
    pulse_src0();
    wait_irq("rdwr_complete_taken", 6);
    bus_read(8'h0C, d);
    bus_write(8'h0C, 32'd1);
  endtask

  task automatic test_empty();
    logic [31:0] d;
    @(negedge clk);
    bus_read(8'h0C, d);
    checks++;
    if (d !== 32'd0 || irq_out !== 1'b0) begin
      errors++; $display("FAIL empty_claim: CLAIM=%0d irq_out=%b required 0/0", d, irq_out);
    end
    bus_read(8'h20, d);
    checks++;
    if (d !== 32'd0) begin
      errors++; $display("FAIL unmapped_read: rdata=%h required 0", d);
    end
    bus_addr = 32'h04;
    #1;
    checks++;
    if (bus_rdata !== 32'd0) begin
      errors++; $display("FAIL no_rd_strobe: rdata=%h required 0", bus_rdata);
    end
    @(negedge clk);
    bus_addr = 32'h0;
    bus_write(8'h04, 32'hFFFF_FFFF);
    bus_read(8'h04, d);
    checks++;
    if (d !== 32'hFF) begin
      errors++; $display("FAIL enable_width: ENABLE=%h required ff", d);
    end
    bus_write(8'h08, 32'hFFFF_FF0F);
    bus_read(8'h08, d);
    checks++;
    if (d !== 32'h0F) begin
      errors++; $display("FAIL edge_sel_rw: EDGE_SEL=%h required 0f", d);
    end
  endtask

  task automatic test_reset_mid_service();
    logic [31:0] d;
    bus_write(8'h08, 32'h0);
    irq_src = 8'h04;
    wait_irq("rst_assert", 8);
    bus_read(8'h0C, d);
    checks++;
    if (d !== 32'd3) begin
      errors++; $display("FAIL rst_claim: CLAIM=%0d required 3", d);
    end
    reset = 1'b1; irq_src = 8'h00;
    bus_addr = 32'h04; bus_rd = 1'b1;
    #1;
    checks++;
    if (bus_rdata !== 32'd0) begin
      errors++; $display("FAIL rdata_in_reset: rdata=%h required 0", bus_rdata);
    end
    @(negedge clk);
    reset = 1'b0; bus_rd = 1'b0; bus_addr = 32'h0;
    checks++;
    if (irq_out !== 1'b0) begin
      errors++; $display("FAIL rst_irq: irq_out=%b required 0", irq_out);
    end
    bus_read(8'h04, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL rst_enable: ENABLE=%h required 0", d);
    end
    bus_read(8'h00, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL rst_pending: PENDING=%h required 0", d);
    end
    bus_read(8'h0C, d);
    checks++;
    if (d !== 32'd0) begin
      errors++; $display("FAIL rst_claim_zero: CLAIM=%0d required 0", d);
    end
    bus_write(8'h04, 32'h1);
    irq_src = 8'h01;
    wait_irq("rst_no_complete_needed", 8);
    bus_read(8'h0C, d);
    checks++;
    if (d !== 32'd1) begin
      errors++; $display("FAIL rst_new_claim: CLAIM=%0d required 1", d);
    end
    irq_src = 8'h00;
  endtask

  initial begin
    reset     = 1'b1;
    irq_src   = 8'h00;
    bus_addr  = 32'h0;
    bus_wr    = 1'b0;
    bus_rd    = 1'b0;
    bus_wdata = 32'h0;
    test_reset();
    test_edge();
    test_priority();
    test_bad_complete();
    test_back_to_back();
    test_empty();
    test_reset_mid_service();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
